// File: rtl/round_sched_ctrl_if.sv
// Bundle between the top-level start/done interface, the key-schedule unit and the
// round scheduler. The master drives requests and acks; the slave is the scheduler.
interface round_sched_ctrl_if #(
  parameter int N = 6
);
  logic         start;
  logic [N-1:0] rounds;
  logic         abort;
  logic         key_ack;
  logic         busy;
  logic         load_en;
  logic         key_req;
  logic         round_en;
  logic [N-1:0] round_idx;
  logic         final_en;
  logic         done;

  modport master (
    output start, rounds, abort, key_ack,
    input  busy, load_en, key_req, round_en, round_idx, final_en, done
  );

  modport slave (
    input  start, rounds, abort, key_ack,
    output busy, load_en, key_req, round_en, round_idx, final_en, done
  );
endinterface

// File: rtl/round_sched_ctrl.sv
// Round scheduler for one cipher block operation: loads the block, runs a programmable
// number of rounds (each gated on a valid round key), then latches the output block.
module round_sched_ctrl #(
  parameter int N = 6
) (
  input  logic             clk,
  input  logic             rst,
  round_sched_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_KEY_WAIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_e;

  localparam logic [N-1:0] ONE = N'(1);

  state_e       state_q, state_d;
  logic [N-1:0] rounds_q, rounds_d;
  logic [N-1:0] round_idx_q, round_idx_d;
  logic         last_round;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rounds_q    <= '0;
      round_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rounds_q    <= rounds_d;
      round_idx_q <= round_idx_d;
    end
  end

  // Guarding on rounds_q != 0 keeps rounds_q-1 from ever being used as an underflowed value.
  assign last_round = (rounds_q != '0) && (round_idx_q == rounds_q - ONE);

  // NOTE: every variable gets a default at the top of the block so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    rounds_d    = rounds_q;
    round_idx_d = round_idx_q;
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      round_idx_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_d     = S_INIT;
            rounds_d    = bus.rounds;
            round_idx_d = '0;
          end
        end
        S_INIT:     state_d = (rounds_q != '0) ? S_KEY_WAIT : S_FINAL;
        S_KEY_WAIT: if (bus.key_ack) state_d = S_ROUND;
        S_ROUND: begin
          round_idx_d = round_idx_q + ONE;
          state_d     = last_round ? S_FINAL : S_KEY_WAIT;
        end
        S_FINAL:    state_d = S_DONE;
        S_DONE:     state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.load_en   = (state_q == S_INIT);
    bus.key_req   = (state_q == S_KEY_WAIT);
    bus.round_en  = (state_q == S_ROUND);
    bus.final_en  = (state_q == S_FINAL);
    bus.done      = (state_q == S_DONE);
    bus.round_idx = round_idx_q;
  end

endmodule

// File: tb/tb_round_sched_ctrl.sv
// Self-checking bench for round_sched_ctrl: directed vector table, hand-written corner
// sequences and randomized operations checked against a schedule-level reference model.
module tb_round_sched_ctrl;

  localparam int N = 6;

  logic clk;
  logic rst;

  round_sched_ctrl_if #(.N(N)) bus ();

  round_sched_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         busy;
    logic         load_en;
    logic         key_req;
    logic         round_en;
    logic         final_en;
    logic         done;
    logic [N-1:0] idx;
  } obs_t;

  // Phase codes: 0 idle, 1 load, 2 key wait, 3 round, 4 final, 5 done.
  typedef struct {
    bit           start;
    logic [N-1:0] rounds;
    bit           abort;
    bit           ack;
    int           ph;
    int           idx;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;
  int last_idx = 0;
  int dly [64];

  function automatic obs_t exp_of(input int ph, input int idx);
    obs_t o;
    o.busy     = (ph != 0);
    o.load_en  = (ph == 1);
    o.key_req  = (ph == 2);
    o.round_en = (ph == 3);
    o.final_en = (ph == 4);
    o.done     = (ph == 5);
    o.idx      = N'(idx);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.busy     = bus.busy;
    o.load_en  = bus.load_en;
    o.key_req  = bus.key_req;
    o.round_en = bus.round_en;
    o.final_en = bus.final_en;
    o.done     = bus.done;
    o.idx      = bus.round_idx;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("busy=%b load=%b kreq=%b ren=%b fin=%b done=%b idx=%0d",
                     o.busy, o.load_en, o.key_req, o.round_en, o.final_en, o.done, o.idx);
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.key_ack = 1'b0;
  endtask

  // One operation of r rounds; round k waits dly[k] extra key_req cycles before ack.
  // abort_cycle: -1 none, -2 pick a random busy cycle, otherwise that cycle index.
  task automatic run_op(input string tag, input int r, input int abort_cycle, input bit noise);
    int ph [$];
    int ix [$];
    bit ack [$];
    int ab;
    ph.push_back(0); ix.push_back(last_idx); ack.push_back(1'b0);
    ph.push_back(1); ix.push_back(0);        ack.push_back(1'b0);
    for (int k = 0; k < r; k++) begin
      for (int j = 0; j <= dly[k]; j++) begin
        ph.push_back(2); ix.push_back(k); ack.push_back(j == dly[k]);
      end
      ph.push_back(3); ix.push_back(k); ack.push_back(1'b0);
    end
    ph.push_back(4); ix.push_back(r); ack.push_back(1'b0);
    ph.push_back(5); ix.push_back(r); ack.push_back(1'b0);
    ph.push_back(0); ix.push_back(r); ack.push_back(1'b0);

    ab = abort_cycle;
    if (ab == -2) ab = (($urandom_range(0, 3) == 0) ? $urandom_range(1, ph.size() - 2) : -1);
    if (ab >= 1 && ab <= ph.size() - 2) begin
      ph  = ph[0:ab];
      ix  = ix[0:ab];
      ack = ack[0:ab];
      ph.push_back(0); ix.push_back(0); ack.push_back(1'b0);
    end else begin
      ab = -1;
    end

    for (int t = 0; t < ph.size(); t++) begin
      bus.start   = (t == 0) ? 1'b1 : ((noise && t < ph.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      bus.rounds  = (t == 0 || !noise) ? N'(r) : N'($urandom);
      bus.abort   = (t == ab);
      bus.key_ack = (ph[t] == 2) ? ack[t] : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      check($sformatf("%s c%0d", tag, t), sample(), exp_of(ph[t], ix[t]));
      step();
    end
    last_idx = ix[ix.size() - 1];
    drive_idle();
  endtask

  task automatic clear_dly();
    for (int k = 0; k < 64; k++) dly[k] = 0;
  endtask

  vec_t vecs [16];

  initial begin
    // {start, rounds, abort, ack, expected phase, expected idx}
    vecs[0]  = '{1'b0, 6'd0, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{1'b1, 6'd5, 1'b1, 1'b0, 0, 0};
    vecs[2]  = '{1'b0, 6'd5, 1'b0, 1'b0, 0, 0};
    vecs[3]  = '{1'b1, 6'd0, 1'b0, 1'b1, 0, 0};
    vecs[4]  = '{1'b1, 6'd7, 1'b0, 1'b1, 1, 0};
    vecs[5]  = '{1'b0, 6'd7, 1'b0, 1'b1, 4, 0};
    vecs[6]  = '{1'b1, 6'd7, 1'b0, 1'b0, 5, 0};
    vecs[7]  = '{1'b0, 6'd0, 1'b0, 1'b0, 0, 0};
    vecs[8]  = '{1'b1, 6'd1, 1'b0, 1'b1, 0, 0};
    vecs[9]  = '{1'b0, 6'd9, 1'b0, 1'b1, 1, 0};
    vecs[10] = '{1'b0, 6'd9, 1'b0, 1'b1, 2, 0};
    vecs[11] = '{1'b0, 6'd9, 1'b0, 1'b0, 3, 0};
    vecs[12] = '{1'b0, 6'd9, 1'b0, 1'b0, 4, 1};
    vecs[13] = '{1'b1, 6'd9, 1'b0, 1'b0, 5, 1};
    vecs[14] = '{1'b0, 6'd9, 1'b0, 1'b0, 0, 1};
    vecs[15] = '{1'b0, 6'd9, 1'b0, 1'b0, 0, 1};

    rst = 1'b0;
    bus.rounds = '0;
    drive_idle();
    clear_dly();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", sample(), exp_of(0, 0));
    rst = 1'b1;

    // Directed table: abort beats start in IDLE, zero rounds, single round, start in DONE.
    for (int i = 0; i < 16; i++) begin
      bus.start   = vecs[i].start;
      bus.rounds  = vecs[i].rounds;
      bus.abort   = vecs[i].abort;
      bus.key_ack = vecs[i].ack;
      check($sformatf("vec%0d", i), sample(), exp_of(vecs[i].ph, vecs[i].idx));
      step();
    end
    drive_idle();
    last_idx = 1;

    // Reset mid-ROUND: R=10, round 4 is in cycle 11; outputs clear the same cycle.
    bus.start  = 1'b1;
    bus.rounds = 6'd10;
    step();
    bus.start   = 1'b0;
    bus.key_ack = 1'b1;
    repeat (10) step();
    check("pre_rst_round4", sample(), exp_of(3, 4));
    #2 rst = 1'b0;
    #1 check("rst_same_cycle", sample(), exp_of(0, 0));
    step();
    check("rst_held", sample(), exp_of(0, 0));
    rst = 1'b1;
    drive_idle();
    last_idx = 0;
    run_op("post_rst", 2, -1, 1'b0);

    // Ten rounds with ack tied high: final_en in cycle 22, done in cycle 23.
    clear_dly();
    run_op("r10", 10, -1, 1'b0);

    // Zero rounds: INIT, FINAL, DONE in cycles 1-3.
    run_op("r0", 0, -1, 1'b0);

    // Three rounds with key delays 2/0/5.
    dly[0] = 2; dly[1] = 0; dly[2] = 5;
    run_op("r3_dly", 3, -1, 1'b0);
    clear_dly();

    // Start pulses and rounds changes while busy are ignored.
    run_op("busy_noise", 4, -1, 1'b1);

    // Abort in the first KEY_WAIT cycle of round 2 (cycle 6 with R=5), then a clean run.
    run_op("abort_kw2", 5, 6, 1'b0);
    run_op("after_abort", 5, -1, 1'b0);

    // Maximum round count: round_idx stops at 63 without wrapping.
    run_op("r63", 63, -1, 1'b0);

    // Randomized operations against the schedule model.
    for (int it = 0; it < 40; it++) begin
      int r;
      r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 12);
      for (int k = 0; k < 64; k++) dly[k] = $urandom_range(0, 3);
      run_op($sformatf("rnd%0d", it), r, -2, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
